// File: rtl/sar_adc_sequencer_if.sv
// Result stream from the SAR sequencer: one slice conversion per beat, valid/ready handshake.
// Master holds out_* stable while out_valid=1 and out_ready=0.
interface sar_adc_sequencer_if #(
    parameter int ADC_BITS   = 8,
    parameter int NUM_SLICES = 4
);
    localparam int SEL_W = $clog2(NUM_SLICES);

    logic                out_valid;
    logic                out_ready;
    logic [ADC_BITS-1:0] out_data;
    logic [SEL_W-1:0]    out_slice;
    logic                out_timeout;

    modport master (
        output out_valid,
        output out_data,
        output out_slice,
        output out_timeout,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_slice,
        input  out_timeout,
        output out_ready
    );
endinterface

// File: rtl/sar_adc_sequencer.sv
// Round-robin sequencer for a bank of SAR slices: sample, convert (with timeout), capture, stream out.
// Latency SAMPLE_CYCLES + conversion + 2-flop sync + 1 capture cycle; backpressure stalls in CAPTURE, nothing dropped.
module sar_adc_sequencer #(
    parameter int ADC_BITS       = 8,
    parameter int NUM_SLICES     = 4,
    parameter int SAMPLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_SLICES-1:0]          slice_mask,
    input  logic [NUM_SLICES-1:0]          slice_compl,
    input  logic [NUM_SLICES*ADC_BITS-1:0] slice_data,
    output logic [NUM_SLICES-1:0]          slice_rst_n,
    output logic [7:0]                     err_cnt,
    output logic                           busy,
    sar_adc_sequencer_if.master            out_if
);
    localparam int SEL_W   = $clog2(NUM_SLICES);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SAMPLE_CYCLES) ? TIMEOUT_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic [7:0]          err_q, err_d;
    logic [NUM_SLICES-1:0] compl_s1_q, compl_s2_q;
    logic                out_valid_q, out_valid_d;
    logic [ADC_BITS-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_slice_q, out_slice_d;
    logic                out_timeout_q, out_timeout_d;

    logic [SEL_W-1:0]    nxt_ptr;
    logic [ADC_BITS-1:0] cur_data;

    // First set mask bit at or after start, wrapping; caller guarantees mask != 0.
    function automatic logic [SEL_W-1:0] first_set(input logic [NUM_SLICES-1:0] m,
                                                   input logic [SEL_W-1:0]      start);
        logic [SEL_W-1:0] r;
        logic             found;
        int               idx;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            idx = (int'(start) + i) % NUM_SLICES;
            if (!found && m[idx[SEL_W-1:0]]) begin
                r     = idx[SEL_W-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign cur_data = slice_data[int'(sel_q)*ADC_BITS +: ADC_BITS];
    assign nxt_ptr  = (int'(sel_q) == NUM_SLICES - 1) ? '0 : sel_q + SEL_W'(1);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        flag_d        = flag_q;
        err_d         = err_q;
        out_valid_d   = out_valid_q & ~out_if.out_ready;
        out_data_d    = out_data_q;
        out_slice_d   = out_slice_q;
        out_timeout_d = out_timeout_q;
        case (state_q)
            IDLE: begin
                if (en && (slice_mask != '0)) begin
                    sel_d   = first_set(slice_mask, ptr_q);
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONVERT: begin
                // A completion seen on the final timer cycle still counts as a good conversion.
                if (compl_s2_q[sel_q]) begin
                    flag_d  = 1'b0;
                    state_d = CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    flag_d  = 1'b1;
                    state_d = CAPTURE;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (!out_valid_q || out_if.out_ready) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = cur_data;
                    out_slice_d   = sel_q;
                    out_timeout_d = flag_q;
                    ptr_d         = nxt_ptr;
                    cnt_d         = '0;
                    if (en && (slice_mask != '0)) begin
                        sel_d   = first_set(slice_mask, nxt_ptr);
                        state_d = SAMPLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            flag_q        <= 1'b0;
            err_q         <= 8'd0;
            compl_s1_q    <= '0;
            compl_s2_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_slice_q   <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            flag_q        <= flag_d;
            err_q         <= err_d;
            compl_s1_q    <= slice_compl;
            compl_s2_q    <= compl_s1_q;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_slice_q   <= out_slice_d;
            out_timeout_q <= out_timeout_d;
        end
    end

    // Selected slice is released only while converting or holding its result.
    always_comb begin
        slice_rst_n = '0;
        if (state_q == CONVERT || state_q == CAPTURE) begin
            slice_rst_n[sel_q] = 1'b1;
        end
    end

    assign busy               = (state_q != IDLE);
    assign err_cnt            = err_q;
    assign out_if.out_valid   = out_valid_q;
    assign out_if.out_data    = out_data_q;
    assign out_if.out_slice   = out_slice_q;
    assign out_if.out_timeout = out_timeout_q;
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Randomized bench: behavioural slice models feed the sequencer; a round-robin model and a conversion queue predict every result.
module tb_sar_adc_sequencer;
    localparam int AB = 8;
    localparam int NS = 4;
    localparam int SC = 2;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NS-1:0]   slice_mask;
    logic [NS-1:0]   slice_compl;
    logic [NS*AB-1:0] slice_data;
    logic [NS-1:0]   slice_rst_n;
    logic [7:0]      err_cnt;
    logic            busy;

    sar_adc_sequencer_if #(.ADC_BITS(AB), .NUM_SLICES(NS)) out_if ();

    sar_adc_sequencer #(
        .ADC_BITS(AB), .NUM_SLICES(NS), .SAMPLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .slice_mask(slice_mask),
        .slice_compl(slice_compl), .slice_data(slice_data),
        .slice_rst_n(slice_rst_n), .err_cnt(err_cnt), .busy(busy), .out_if(out_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sl;
        logic [AB-1:0] dat;
        bit          to;
    } conv_t;

    conv_t        q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           dly[NS];
    int           scnt[NS];
    logic [AB-1:0] sdat[NS];
    int           mptr = 0;
    int           merr = 0;
    int           n_acc = 0;
    int           last_sl = -1;
    int           stab_viol = 0;
    int           mask_viol = 0;
    int           rstn_viol = 0;
    bit           watch_mask = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NS-1:0] m, input int p);
        for (int i = 0; i < NS; i++) if (m[(p + i) % NS]) return (p + i) % NS;
        return -1;
    endfunction

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return TO - 3;
        if (r == 1) return TO - 2;
        return $urandom_range(1, 20);
    endfunction

    // Slice model: fresh sample data while in reset, frozen once released; compl rises dly cycles after release.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (slice_rst_n[i] === 1'b1) begin
                scnt[i]++;
                if (scnt[i] == 1) q.push_back('{i, sdat[i], (dly[i] + 2 > TO - 1)});
            end else begin
                scnt[i] = 0;
                sdat[i] = AB'($urandom);
            end
        end
    end

    always_comb begin
        slice_compl = '0;
        slice_data  = '0;
        for (int i = 0; i < NS; i++) begin
            slice_compl[i]         = slice_rst_n[i] && (scnt[i] > dly[i]);
            slice_data[i*AB +: AB] = sdat[i];
        end
    end

    task automatic accept();
        int    exp_sl;
        conv_t c;
        exp_sl = pick(slice_mask, mptr);
        chk("out_slice", out_if.out_slice, exp_sl);
        chk("conv_pending", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
            c = q.pop_front();
            chk("out_data", out_if.out_data, c.dat);
            chk("out_timeout", out_if.out_timeout, c.to);
            if (c.to && merr < 255) merr++;
        end
        mptr    = (exp_sl + 1) % NS;
        last_sl = int'(out_if.out_slice);
        n_acc++;
    endtask

    logic          h_arm = 1'b0;
    logic [AB-1:0] h_dat;
    logic [1:0]    h_sl;
    logic          h_to;

    always @(negedge clk) begin
        if (rst) begin
            h_arm = 1'b0;
        end else begin
            if (h_arm && (out_if.out_valid !== 1'b1 || out_if.out_data !== h_dat ||
                          out_if.out_slice !== h_sl || out_if.out_timeout !== h_to))
                stab_viol++;
            h_arm = out_if.out_valid && !out_if.out_ready;
            h_dat = out_if.out_data;
            h_sl  = out_if.out_slice;
            h_to  = out_if.out_timeout;
            if ($countones(slice_rst_n) > 1 || (!busy && slice_rst_n != '0)) rstn_viol++;
            if (watch_mask && (slice_rst_n & ~slice_mask) != '0) mask_viol++;
            if (out_if.out_valid && out_if.out_ready) accept();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int k, input bit rnd, input int budget);
        int target;
        int b;
        target = n_acc + k;
        b = 0;
        while (n_acc < target && b < budget) begin
            if (rnd) out_if.out_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            b++;
        end
        chk("accept_budget", int'(n_acc >= target), 1);
        out_if.out_ready = 1'b1;
    endtask

    task automatic drain();
        int b;
        b = 0;
        en = 1'b0;
        out_if.out_ready = 1'b1;
        while ((busy || out_if.out_valid) && b < 300) begin
            tick(1);
            b++;
        end
        tick(1);
        chk("drain_idle", busy | out_if.out_valid, 0);
        chk("err_cnt", err_cnt, merr);
        chk("queue_empty", q.size(), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", out_if.out_valid, 0);
        chk("rst_out_data", out_if.out_data, 0);
        chk("rst_out_slice", out_if.out_slice, 0);
        chk("rst_out_timeout", out_if.out_timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slice_rst_n", slice_rst_n, 0);
    endtask

    initial begin
        int b;
        int c;
        int n0;
        rst = 1'b1;
        en = 1'b0;
        slice_mask = '0;
        out_if.out_ready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            dly[i]  = 10;
            scnt[i] = 0;
            sdat[i] = '0;
        end
        tick(3);
        check_reset_values();
        rst = 1'b0;

        // Full mask, fixed completion delay
        slice_mask = 4'b1111;
        en = 1'b1;
        wait_acc(12, 1'b0, 600);
        drain();

        // Sparse mask: only slices 1 and 3 may ever be released
        slice_mask = 4'b1010;
        watch_mask = 1'b1;
        en = 1'b1;
        wait_acc(8, 1'b0, 500);
        drain();
        watch_mask = 1'b0;
        chk("mask_excluded", mask_viol, 0);

        // Random masks, delays around the timeout boundary, random backpressure
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NS; i++) dly[i] = pick_dly();
            slice_mask = NS'($urandom_range(1, 15));
            en = 1'b1;
            wait_acc(6, 1'b1, 900);
            drain();
        end

        // Long stall
        for (int i = 0; i < NS; i++) dly[i] = 10;
        slice_mask = 4'b1111;
        en = 1'b1;
        wait_acc(2, 1'b0, 200);
        b = 0;
        while (out_if.out_valid !== 1'b1 && b < 100) begin
            tick(1);
            b++;
        end
        out_if.out_ready = 1'b0;
        tick(50);
        chk("stall_valid", out_if.out_valid, 1);
        chk("stall_busy", busy, 1);
        chk("stall_stable", stab_viol, 0);
        out_if.out_ready = 1'b1;
        wait_acc(4, 1'b0, 300);
        drain();

        // en dropped while slice 1 samples
        slice_mask = 4'b0010;
        en = 1'b1;
        tick(1);
        chk("endrop_busy", busy, 1);
        en = 1'b0;
        n0 = n_acc;
        b = 0;
        while ((busy || out_if.out_valid) && b < 100) begin
            tick(1);
            b++;
        end
        tick(1);
        chk("endrop_count", n_acc - n0, 1);
        chk("endrop_slice", last_sl, 1);
        chk("endrop_idle", busy, 0);
        chk("endrop_rstn", slice_rst_n, 0);

        // Reset in the middle of slice 2 conversion
        slice_mask = 4'b0100;
        en = 1'b1;
        b = 0;
        while (slice_rst_n[2] !== 1'b1 && b < 100) begin
            tick(1);
            b++;
        end
        chk("conv2_started", slice_rst_n[2], 1);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        q.delete();
        mptr = 0;
        merr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        slice_mask = 4'b1111;
        wait_acc(1, 1'b0, 200);
        chk("rst_first_slice", last_sl, 0);
        drain();

        // Dead slice 2: timeout latency, flag, and err_cnt saturation
        dly[2] = 1000;
        slice_mask = 4'b0100;
        en = 1'b1;
        b = 0;
        while (slice_rst_n[2] !== 1'b1 && b < 100) begin
            tick(1);
            b++;
        end
        c = 0;
        while (out_if.out_valid !== 1'b1 && c < 100) begin
            tick(1);
            c++;
        end
        chk("timeout_latency", c, TO + 1);
        chk("timeout_slice", out_if.out_slice, 2);
        chk("timeout_flag", out_if.out_timeout, 1);
        chk("err_one", err_cnt, 1);
        wait_acc(300, 1'b0, 12000);
        drain();
        chk("err_saturated", err_cnt, 255);

        chk("rstn_onehot", rstn_viol, 0);
        chk("hold_stable", stab_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
